// File: rtl/note_player_env.sv
// rtl/note_player_env.sv - one-voice note player with pending-note slot and linear envelope
// Envelope build option: NOTE_PLAYER_ENVELOPE_EN (undefined: fixed full gain, IDLE/SUSTAIN only)

module frequency_rom #(
  parameter int NOTE_W  = 6,
  parameter int PHASE_W = 16
) (
  input  logic [NOTE_W-1:0]  note,
  output logic [PHASE_W-1:0] step_size
);
  // Phase step grows linearly with the note number; note 0 still advances.
  localparam int unsigned STEP_SCALE = 97;

  always_comb begin
    step_size = PHASE_W'((32'(note) + 32'd1) * STEP_SCALE);
  end
endmodule

module sine_reader #(
  parameter int PHASE_W  = 16,
  parameter int SAMPLE_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       generate_next,
  input  logic [PHASE_W-1:0]         step_size,
  output logic signed [SAMPLE_W-1:0] sample,
  output logic                       sample_ready
);
  logic [PHASE_W-1:0]         phase_q;
  logic [PHASE_W-1:0]         phase_nxt;
  logic [5:0]                 idx;
  logic [4:0]                 qidx;
  logic [15:0]                mag;
  logic [15:0]                s16;
  logic signed [SAMPLE_W-1:0] lookup;

  // First quadrant of a 64-point sine, amplitude 32767; entry 16 is the peak.
  function automatic logic [15:0] quarter_sine(input logic [4:0] k);
    case (k)
      5'd0:    quarter_sine = 16'd0;
      5'd1:    quarter_sine = 16'd3212;
      5'd2:    quarter_sine = 16'd6393;
      5'd3:    quarter_sine = 16'd9512;
      5'd4:    quarter_sine = 16'd12539;
      5'd5:    quarter_sine = 16'd15446;
      5'd6:    quarter_sine = 16'd18204;
      5'd7:    quarter_sine = 16'd20787;
      5'd8:    quarter_sine = 16'd23170;
      5'd9:    quarter_sine = 16'd25329;
      5'd10:   quarter_sine = 16'd27245;
      5'd11:   quarter_sine = 16'd28898;
      5'd12:   quarter_sine = 16'd30273;
      5'd13:   quarter_sine = 16'd31356;
      5'd14:   quarter_sine = 16'd32137;
      5'd15:   quarter_sine = 16'd32609;
      default: quarter_sine = 16'd32767;
    endcase
  endfunction

  always_comb begin
    phase_nxt = phase_q + step_size;
    idx       = phase_nxt[PHASE_W-1 -: 6];
    // Odd quadrants read the table mirrored, the second half is negated.
    qidx      = idx[4] ? (5'd16 - {1'b0, idx[3:0]}) : {1'b0, idx[3:0]};
    mag       = quarter_sine(qidx);
    s16       = idx[5] ? (16'd0 - mag) : mag;
    lookup    = SAMPLE_W'($signed(s16)) <<< (SAMPLE_W - 16);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q      <= '0;
      sample       <= '0;
      sample_ready <= 1'b0;
    end else if (enable) begin
      sample_ready <= generate_next;
      if (generate_next) begin
        phase_q <= phase_nxt;
        sample  <= lookup;
      end
    end
  end
endmodule

module note_player_env #(
  parameter int NOTE_W       = 6,
  parameter int DUR_W        = 6,
  parameter int SAMPLE_W     = 16,
  parameter int ENV_W        = 4,
  parameter int ATTACK_STEP  = 4,
  parameter int RELEASE_STEP = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       play_enable,
  input  logic [NOTE_W-1:0]          note_to_load,
  input  logic [DUR_W-1:0]           duration_to_load,
  input  logic                       load_new_note,
  output logic                       note_ready,
  output logic                       done_with_note,
  output logic                       busy,
  input  logic                       beat,
  input  logic                       generate_next_sample,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       new_sample_ready
);
  localparam int GW      = ENV_W + 1;
  localparam int GW1     = GW + 1;
  localparam int PHASE_W = 16;
  localparam logic [GW-1:0]    GMAX    = GW'(1 << ENV_W);
  localparam logic [GW:0]      A_STEP  = GW1'(ATTACK_STEP);
  localparam logic [GW-1:0]    R_STEP  = GW'(RELEASE_STEP);
  localparam logic [DUR_W-1:0] DUR_ONE = DUR_W'(1);

  typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} state_t;

  state_t               state_q, state_d;
  logic                 slot_valid_q;
  logic [NOTE_W-1:0]    slot_note_q;
  logic [DUR_W-1:0]     slot_dur_q;
  logic [NOTE_W-1:0]    note_q, note_d;
  logic [DUR_W-1:0]     dur_cnt_q, dur_cnt_d;
  logic [GW-1:0]        gain_q, gain_d;
  logic [GW:0]          gain_up;
  logic [GW-1:0]        gain_down;
  logic                 done_q;
  logic                 tick;
  logic                 load_fire;
  logic                 note_end;
  logic                 start;

  logic [PHASE_W-1:0]         step_size;
  logic signed [SAMPLE_W-1:0] raw_sample;
  logic                       raw_ready;
  logic [GW-1:0]              eff_gain;
  logic signed [SAMPLE_W+GW:0] product;
  logic signed [SAMPLE_W+GW:0] scaled;

  assign tick           = play_enable && beat;
  assign load_fire      = load_new_note && !slot_valid_q;
  assign note_ready     = !slot_valid_q;
  assign busy           = (state_q != IDLE);
  assign done_with_note = done_q;
  assign gain_up        = {1'b0, gain_q} + A_STEP;
  assign gain_down      = (gain_q > R_STEP) ? (gain_q - R_STEP) : '0;

  always_comb begin
    state_d   = state_q;
    note_d    = note_q;
    dur_cnt_d = dur_cnt_q;
    gain_d    = gain_q;
    note_end  = 1'b0;
    start     = 1'b0;
    case (state_q)
      ATTACK: begin
        if (tick) begin
          dur_cnt_d = dur_cnt_q - 1'b1;
          gain_d    = (gain_up >= {1'b0, GMAX}) ? GMAX : gain_up[GW-1:0];
          // The body may end before the ramp tops out; release from wherever it got to.
          if (dur_cnt_q == DUR_ONE) begin
            state_d = RELEASE;
          end else if (gain_d == GMAX) begin
            state_d = SUSTAIN;
          end
        end
      end
      SUSTAIN: begin
        if (tick) begin
          dur_cnt_d = dur_cnt_q - 1'b1;
          if (dur_cnt_q == DUR_ONE) begin
`ifdef NOTE_PLAYER_ENVELOPE_EN
            state_d = RELEASE;
`else
            note_end = 1'b1;
            state_d  = IDLE;
`endif
          end
        end
      end
      RELEASE: begin
        if (tick) begin
          gain_d = gain_down;
          if (gain_down == '0) begin
            note_end = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      default: ;
    endcase

    // A pending note takes over on the finishing edge; its first beat is not consumed here.
    start = play_enable && slot_valid_q && ((state_q == IDLE) || note_end);
    if (start) begin
      note_d    = slot_note_q;
      dur_cnt_d = (slot_dur_q == '0) ? DUR_ONE : slot_dur_q;
`ifdef NOTE_PLAYER_ENVELOPE_EN
      gain_d    = '0;
      state_d   = ATTACK;
`else
      gain_d    = GMAX;
      state_d   = SUSTAIN;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      slot_valid_q <= 1'b0;
      slot_note_q  <= '0;
      slot_dur_q   <= '0;
      note_q       <= '0;
      dur_cnt_q    <= '0;
      gain_q       <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      note_q    <= note_d;
      dur_cnt_q <= dur_cnt_d;
      gain_q    <= gain_d;
      done_q    <= note_end;
      if (start) begin
        slot_valid_q <= 1'b0;
      end else if (load_fire) begin
        slot_valid_q <= 1'b1;
        slot_note_q  <= note_to_load;
        slot_dur_q   <= duration_to_load;
      end
    end
  end

  frequency_rom #(
    .NOTE_W  (NOTE_W),
    .PHASE_W (PHASE_W)
  ) u_frequency_rom (
    .note      (note_q),
    .step_size (step_size)
  );

  sine_reader #(
    .PHASE_W  (PHASE_W),
    .SAMPLE_W (SAMPLE_W)
  ) u_sine_reader (
    .clk           (clk),
    .reset         (reset),
    .enable        (play_enable),
    .generate_next (play_enable && generate_next_sample),
    .step_size     (step_size),
    .sample        (raw_sample),
    .sample_ready  (raw_ready)
  );

  // An idle voice still answers requests, but with silence.
  always_comb begin
    eff_gain = (state_q == IDLE) ? '0 : gain_q;
    product  = raw_sample * $signed({1'b0, eff_gain});
    scaled   = product >>> ENV_W;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_out       <= '0;
      new_sample_ready <= 1'b0;
    end else if (play_enable) begin
      new_sample_ready <= raw_ready;
      if (raw_ready) begin
        sample_out <= scaled[SAMPLE_W-1:0];
      end
    end else begin
      new_sample_ready <= 1'b0;
    end
  end
endmodule

// File: tb/tb_note_player_env.sv
// tb/tb_note_player_env.sv - randomized and directed checks of note_player_env against a behavioural model

module tb_note_player_env;
  localparam int ENV_W  = 4;
  localparam int GMAX   = 16;
  localparam int A_STEP = 4;
  localparam int R_STEP = 4;
`ifdef NOTE_PLAYER_ENVELOPE_EN
  localparam bit ENV_EN = 1'b1;
`else
  localparam bit ENV_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic               play_enable;
  logic [5:0]         note_to_load;
  logic [5:0]         duration_to_load;
  logic               load_new_note;
  logic               note_ready;
  logic               done_with_note;
  logic               busy;
  logic               beat;
  logic               generate_next_sample;
  logic signed [15:0] sample_out;
  logic               new_sample_ready;

  always #5 clk = ~clk;

  note_player_env dut (
    .clk                  (clk),
    .reset                (reset),
    .play_enable          (play_enable),
    .note_to_load         (note_to_load),
    .duration_to_load     (duration_to_load),
    .load_new_note        (load_new_note),
    .note_ready           (note_ready),
    .done_with_note       (done_with_note),
    .busy                 (busy),
    .beat                 (beat),
    .generate_next_sample (generate_next_sample),
    .sample_out           (sample_out),
    .new_sample_ready     (new_sample_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a playing note is (beats left, gain, releasing) plus a one-entry pending queue.
  bit m_active, m_rel, m_pvalid, m_done, m_raw_rdy, m_out_rdy;
  int m_note, m_left, m_gain, m_pnote, m_pdur, m_phase, m_raw, m_out;
  logic o_done, o_busy, o_ready;

  function automatic int sine_ref(input int idx);
    real v;
    v = 32767.0 * $sin(6.283185307179586 * real'(idx) / 64.0);
    return int'(v);
  endfunction

  function automatic int expected_beats(input int dur);
    int d;
    int g;
    d = (dur == 0) ? 1 : dur;
    if (!ENV_EN) return d;
    g = (A_STEP * d > GMAX) ? GMAX : A_STEP * d;
    return d + (g + R_STEP - 1) / R_STEP;
  endfunction

  task automatic model_reset();
    m_active = 0; m_rel = 0; m_pvalid = 0; m_done = 0; m_raw_rdy = 0; m_out_rdy = 0;
    m_note = 0; m_left = 0; m_gain = 0; m_pnote = 0; m_pdur = 0;
    m_phase = 0; m_raw = 0; m_out = 0;
  endtask

  task automatic model_step(input bit pe, input bit bt, input bit gen, input bit ld,
                            input int ln, input int ldur);
    bit end_evt;
    bit was_active;
    bit load_ok;
    end_evt    = 0;
    was_active = m_active;
    load_ok    = ld && !m_pvalid;
    if (pe) begin
      if (m_raw_rdy) m_out = m_active ? ((m_raw * m_gain) >>> ENV_W) : 0;
      m_out_rdy = m_raw_rdy;
      m_raw_rdy = gen;
      if (gen) begin
        m_phase = (m_phase + (m_note + 1) * 97) & 16'hffff;
        m_raw   = sine_ref(m_phase >> 10);
      end
    end else begin
      m_out_rdy = 0;
    end
    if (m_active && pe && bt) begin
      if (!m_rel) begin
        m_left--;
        if (ENV_EN) m_gain = (m_gain + A_STEP > GMAX) ? GMAX : m_gain + A_STEP;
        if (m_left == 0) begin
          if (ENV_EN) m_rel = 1;
          else end_evt = 1;
        end
      end else begin
        m_gain = (m_gain - R_STEP < 0) ? 0 : m_gain - R_STEP;
        if (m_gain == 0) end_evt = 1;
      end
    end
    if (end_evt) m_active = 0;
    m_done = end_evt;
    if (pe && m_pvalid && (!was_active || end_evt)) begin
      m_active = 1;
      m_rel    = 0;
      m_note   = m_pnote;
      m_left   = (m_pdur == 0) ? 1 : m_pdur;
      m_gain   = ENV_EN ? 0 : GMAX;
      m_pvalid = 0;
    end
    if (load_ok) begin
      m_pvalid = 1;
      m_pnote  = ln;
      m_pdur   = ldur;
    end
  endtask

  task automatic check_outputs();
    logic signed [63:0] so;
    logic signed [63:0] diff;
    check("note_ready", note_ready, !m_pvalid);
    check("busy", busy, m_active);
    check("done_with_note", done_with_note, m_done);
    check("new_sample_ready", new_sample_ready, m_out_rdy);
    so   = sample_out;
    diff = so - m_out;
    check("sample_out", (diff >= -2 && diff <= 2) ? m_out : so, m_out);
  endtask

  task automatic check_reset_values();
    check("rst_note_ready", note_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done_with_note, 0);
    check("rst_sample_out", sample_out, 0);
    check("rst_new_sample_ready", new_sample_ready, 0);
  endtask

  task automatic drive(input bit pe, input bit bt, input bit gen, input bit ld, input int ln, input int ldur);
    play_enable          = pe;
    beat                 = bt;
    generate_next_sample = gen;
    load_new_note        = ld;
    note_to_load         = 6'(ln);
    duration_to_load     = 6'(ldur);
  endtask

  task automatic cycle(input bit pe, input bit bt, input bit gen, input bit ld, input int ln, input int ldur);
    @(negedge clk);
    check_outputs();
    o_done  = done_with_note;
    o_busy  = busy;
    o_ready = note_ready;
    drive(pe, bt, gen, ld, ln, ldur);
    model_step(pe, bt, gen, ld, ln & 63, ldur & 63);
  endtask

  task automatic apply_reset(input bit mid_cycle);
    @(negedge clk);
    if (mid_cycle) begin
      #2 reset = 1'b0;
      #1 check_reset_values();
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 63), $urandom_range(0, 63));
      @(negedge clk);
      check_reset_values();
    end
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    reset = 1'b1;
    model_step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic run_note(input int note, input int dur, input bit pause);
    int beats;
    int cyc;
    int hold;
    bit got;
    bit pe;
    bit bt;
    beats = 0;
    cyc   = 0;
    got   = 0;
    hold  = pause ? 20 : 0;
    cycle(1, 0, 0, 1, note, dur);
    cycle(1, 1, 1, 0, 0, 0);
    check("ready_low_slot_full", o_ready, 0);
    cycle(1, 0, 0, 0, 0, 0);
    check("start_busy", o_busy, 1);
    check("ready_after_start", o_ready, 1);
    while (!got && cyc < 800) begin
      bt = (cyc % 4 == 3);
      pe = 1;
      if (beats == 6 && hold > 0) begin
        pe = 0;
        hold--;
      end
      cycle(pe, bt, cyc[0], 0, 0, 0);
      if (o_done) got = 1;
      else if (pe && bt) beats++;
      cyc++;
    end
    check("note_beats", got ? beats : -1, expected_beats(dur));
    cycle(1, 0, 1, 0, 0, 0);
    check("idle_after_done", o_busy, 0);
  endtask

  task automatic gapless(input int na, input int da, input int nb, input int db);
    int beats;
    int dones;
    int cyc;
    bit dropped;
    beats   = 0;
    dones   = 0;
    cyc     = 0;
    dropped = 0;
    cycle(1, 0, 0, 1, na, da);
    for (int i = 0; i < 3; i++) cycle(1, 0, 1, 1, nb, db);
    while (dones < 2 && cyc < 800) begin
      cycle(1, (cyc % 4 == 3), cyc[0], 0, 0, 0);
      if (o_done) dones++;
      if (!o_busy && dones < 2) dropped = 1;
      if (dones < 2 && (cyc % 4 == 3)) beats++;
      cyc++;
    end
    check("gapless_dones", dones, 2);
    check("gapless_no_idle", dropped, 0);
    check("gapless_beats", beats, expected_beats(da) + expected_beats(db));
  endtask

  task automatic random_run(input int n);
    int pe_off;
    bit pe;
    pe_off = 0;
    for (int i = 0; i < n; i++) begin
      if (pe_off > 0) begin
        pe = 0;
        pe_off--;
      end else begin
        pe = 1;
        if ($urandom_range(0, 39) == 0) pe_off = $urandom_range(1, 12);
      end
      cycle(pe, $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 63), $urandom_range(0, 7));
    end
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    apply_reset(0);
    run_note(20, 3, 0);
    run_note(33, 10, 0);
    run_note(5, 2, 0);
    run_note(47, 10, 1);
    run_note(60, 0, 0);
    gapless(12, 2, 40, 3);
    random_run(2000);
    apply_reset(1);
    random_run(1500);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
